kernel_bc_fifo_wr_arb: RTL and testbench

- Round-robin burst arbiter that shares one kernel_bc shift-register FIFO write port among NREQ upstream FIFOs.
- Pops words from the upstream FIFO read sides and registers them through a single output stage into the downstream FIFO write side.
- Sits between the per-PE result FIFOs and the shared output FIFO of the kernel_bc dataflow region.

---
 rtl/kernel_bc_fifo_wr_arb.sv | 166 ++++++++++++++++
 tb/tb_kernel_bc_fifo_wr_arb.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_bc_fifo_wr_arb.sv
// Round-robin burst arbiter sharing one downstream FIFO write port among
// NREQ upstream FIFOs. Words are popped from the granted requester and
// registered through a single output stage into the downstream FIFO.
module kernel_bc_fifo_wr_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int NREQ       = 4,
    parameter int GNT_WIDTH  = 2,
    parameter int MAX_BURST  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req_empty_n,
    output logic [NREQ-1:0]            req_read,
    input  logic [NREQ*DATA_WIDTH-1:0] req_dout,
    input  logic [NREQ-1:0]            cfg_enable,
    input  logic                       out_full_n,
    output logic                       out_write,
    output logic [DATA_WIDTH-1:0]      out_din,
    output logic [GNT_WIDTH-1:0]       grant_id,
    output logic                       busy,
    output logic [31:0]                xfer_count
);

    localparam int BCW = $clog2(MAX_BURST) + 1;
    localparam logic [BCW-1:0]       BURST_LAST = BCW'(MAX_BURST - 1);
    localparam logic [GNT_WIDTH-1:0] GNT_RESET  = GNT_WIDTH'(NREQ - 1);
    localparam logic [GNT_WIDTH:0]   NREQ_W     = (GNT_WIDTH + 1)'(NREQ);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t                 state_reg, state_next;
    logic [GNT_WIDTH-1:0]   grant_reg, grant_next;
    logic [BCW-1:0]         burst_reg, burst_next;
    logic                   out_valid_reg;
    logic [DATA_WIDTH-1:0]  out_data_reg;
    logic [31:0]            xfer_reg;

    logic [DATA_WIDTH-1:0]  word_in [NREQ];
    logic [NREQ-1:0]        eligible;
    logic [GNT_WIDTH-1:0]   cand_idx [NREQ];
    logic [NREQ-1:0]        cand_ok;
    logic                   pick_found;
    logic [GNT_WIDTH-1:0]   pick_idx;
    logic                   cur_avail;
    logic                   ld;
    logic                   take;
    logic                   deliver;

    // Split the concatenated upstream data bus into one word per requester.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_word
            assign word_in[gi] = req_dout[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign eligible = req_empty_n & cfg_enable;

    // Candidate gi is the requester (gi+1) positions after the last grant,
    // wrapped modulo NREQ; candidate 0 therefore has the highest priority.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
            logic [GNT_WIDTH:0] cand_sum;
            assign cand_sum     = {1'b0, grant_reg} + (GNT_WIDTH + 1)'(gi + 1);
            assign cand_idx[gi] = (cand_sum >= NREQ_W) ? GNT_WIDTH'(cand_sum - NREQ_W)
                                                       : GNT_WIDTH'(cand_sum);
            assign cand_ok[gi]  = eligible[cand_idx[gi]];
        end
    endgenerate

    // Select the nearest eligible candidate in rotation order.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = grant_reg;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (cand_ok[k]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx[k];
            end
        end
    end

    // Output stage may accept a new word when empty or draining this cycle.
    assign ld        = !out_valid_reg | out_full_n;
    assign cur_avail = req_empty_n[grant_reg] & cfg_enable[grant_reg];
    assign take      = (state_reg == S_GRANT) & cur_avail & ld;
    assign deliver   = out_valid_reg & out_full_n;

    // Next-state, burst bookkeeping and the one-hot pop strobe.
    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        burst_next = burst_reg;
        req_read   = '0;
        case (state_reg)
            S_IDLE: begin
                if (pick_found) begin
                    grant_next = pick_idx;
                    burst_next = '0;
                    state_next = S_GRANT;
                end
            end
            S_GRANT: begin
                if (!cur_avail) begin
                    // Requester drained or masked: give up the grant, no pop.
                    state_next = S_IDLE;
                end else if (ld) begin
                    req_read[grant_reg] = 1'b1;
                    burst_next          = burst_reg + BCW'(1);
                    if (burst_reg == BURST_LAST) begin
                        state_next = S_IDLE;
                    end
                end
                // ld low: downstream is holding a word, wait with counter frozen.
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
            grant_reg <= GNT_RESET;
            burst_reg <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            burst_reg <= burst_next;
        end
    end

    // Single output register: a pop overwrites it (even while it is being
    // delivered), otherwise a delivery empties it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else if (take) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= word_in[grant_reg];
        end else if (out_full_n) begin
            out_valid_reg <= 1'b0;
        end
    end

    // Count words accepted by the downstream FIFO; wraps naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xfer_reg <= '0;
        end else if (deliver) begin
            xfer_reg <= xfer_reg + 32'd1;
        end
    end

    assign out_write  = out_valid_reg;
    assign out_din    = out_data_reg;
    assign grant_id   = grant_reg;
    assign busy       = (state_reg == S_GRANT) | out_valid_reg;
    assign xfer_count = xfer_reg;

endmodule

// File: tb/tb_kernel_bc_fifo_wr_arb.sv
// Directed testbench for kernel_bc_fifo_wr_arb. Upstream FIFOs are modelled
// as counters: requester i word n carries 32'hA00i_nnnn.
module tb_kernel_bc_fifo_wr_arb;

    localparam int DW  = 32;
    localparam int NR  = 4;
    localparam int GW  = 2;
    localparam int MB  = 4;
    localparam int INF = 32'h7fff_ffff;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [NR-1:0]    req_empty_n;
    logic [NR-1:0]    req_read;
    logic [NR*DW-1:0] req_dout;
    logic [NR-1:0]    cfg_enable;
    logic             out_full_n;
    logic             out_write;
    logic [DW-1:0]    out_din;
    logic [GW-1:0]    grant_id;
    logic             busy;
    logic [31:0]      xfer_count;

    int          fill [NR];
    int          popped [NR] = '{default: 0};
    logic        model_clr = 1'b0;
    int          cyc = 0;
    int          pop_cyc [$];
    int          pop_id [$];
    logic [DW-1:0] dlog [$];
    int          checks = 0;
    int          passes = 0;

    kernel_bc_fifo_wr_arb #(
        .DATA_WIDTH(DW),
        .NREQ      (NR),
        .GNT_WIDTH (GW),
        .MAX_BURST (MB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_empty_n(req_empty_n),
        .req_read   (req_read),
        .req_dout   (req_dout),
        .cfg_enable (cfg_enable),
        .out_full_n (out_full_n),
        .out_write  (out_write),
        .out_din    (out_din),
        .grant_id   (grant_id),
        .busy       (busy),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] word(input int i, input int n);
        return 32'hA000_0000 | (32'(i) << 16) | 32'(n & 32'h0000_ffff);
    endfunction

    generate
        for (genvar gi = 0; gi < NR; gi++) begin : g_src
            assign req_empty_n[gi]          = (popped[gi] < fill[gi]);
            assign req_dout[gi*DW +: DW]    = word(gi, popped[gi]);
        end
    endgenerate

    // Upstream FIFO model plus pop/delivery logging.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (model_clr) begin
            pop_cyc.delete();
            pop_id.delete();
            dlog.delete();
            for (int i = 0; i < NR; i++) popped[i] <= 0;
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (req_read[i]) begin
                    popped[i] <= popped[i] + 1;
                    pop_cyc.push_back(cyc);
                    pop_id.push_back(i);
                end
            end
            if (out_write && out_full_n) dlog.push_back(out_din);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Assert reset, empty the source model and clear the logs; reset stays low.
    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b0;
        model_clr = 1'b1;
        for (int i = 0; i < NR; i++) fill[i] = 0;
        cfg_enable = '1;
        out_full_n = 1'b1;
        @(negedge clk);
        model_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_pops(input int n, input int budget, input string tag);
        int k = 0;
        while (pop_id.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (pop_id.size() < n)
            $display("FAIL %s: timeout, pops=%0d required=%0d", tag, pop_id.size(), n);
        else
            passes++;
    endtask

    task automatic test_reset();
        model_clr  = 1'b1;
        for (int i = 0; i < NR; i++) fill[i] = INF;
        cfg_enable = '1;
        out_full_n = 1'b1;
        repeat (3) @(negedge clk);
        model_clr = 1'b0;
        @(negedge clk);
        checks++; if (out_write !== 1'b0) $display("FAIL rst_out_write: got %b want 0", out_write); else passes++;
        checks++; if (req_read !== 4'b0000) $display("FAIL rst_req_read: got %b want 0000", req_read); else passes++;
        checks++; if (grant_id !== 2'd3) $display("FAIL rst_grant_id: got %0d want 3", grant_id); else passes++;
        checks++; if (xfer_count !== 32'd0) $display("FAIL rst_xfer: got %0d want 0", xfer_count); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passes++;
        checks++; if (out_din !== 32'd0) $display("FAIL rst_out_din: got %h want 0", out_din); else passes++;
        reset = 1'b1;
        @(negedge clk);
        checks++; if (grant_id !== 2'd0) $display("FAIL rst_first_grant: got %0d want 0", grant_id); else passes++;
        checks++; if (req_read !== 4'b0001) $display("FAIL rst_first_pop: got %b want 0001", req_read); else passes++;
        $display("test_reset done: grant_id=%0d req_read=%b", grant_id, req_read);
    endtask

    task automatic test_single();
        int off [10] = '{0, 1, 2, 3, 5, 6, 7, 8, 10, 11};
        do_reset();
        fill[2] = 10;
        reset   = 1'b1;
        wait_pops(10, 60, "single_pops");
        repeat (4) @(negedge clk);
        checks++; if (pop_id.size() !== 10) $display("FAIL single_pop_count: got %0d want 10", pop_id.size()); else passes++;
        for (int k = 0; k < 10 && k < pop_id.size(); k++) begin
            checks++;
            if (pop_cyc[k] - pop_cyc[0] !== off[k])
                $display("FAIL single_pop_cycle[%0d]: got %0d want %0d", k, pop_cyc[k] - pop_cyc[0], off[k]);
            else passes++;
        end
        checks++; if (dlog.size() !== 10) $display("FAIL single_deliver_count: got %0d want 10", dlog.size()); else passes++;
        for (int k = 0; k < 10 && k < dlog.size(); k++) begin
            checks++;
            if (dlog[k] !== word(2, k))
                $display("FAIL single_data[%0d]: got %h want %h", k, dlog[k], word(2, k));
            else passes++;
        end
        checks++; if (xfer_count !== 32'd10) $display("FAIL single_xfer: got %0d want 10", xfer_count); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL single_busy_end: got %b want 0", busy); else passes++;
        $display("test_single done: pops=%0d delivered=%0d xfer=%0d", pop_id.size(), dlog.size(), xfer_count);
    endtask

    task automatic test_all_four();
        do_reset();
        for (int i = 0; i < NR; i++) fill[i] = INF;
        reset = 1'b1;
        repeat (20) @(negedge clk);
        checks++; if (xfer_count !== 32'd15) $display("FAIL all4_xfer_c20: got %0d want 15", xfer_count); else passes++;
        @(negedge clk);
        checks++; if (xfer_count !== 32'd16) $display("FAIL all4_xfer_c21: got %0d want 16", xfer_count); else passes++;
        wait_pops(17, 40, "all4_pops");
        for (int k = 0; k < 17 && k < pop_id.size(); k++) begin
            checks++;
            if (pop_id[k] !== (k / 4) % 4)
                $display("FAIL all4_grant[%0d]: got %0d want %0d", k, pop_id[k], (k / 4) % 4);
            else passes++;
            checks++;
            if (pop_cyc[k] - pop_cyc[0] !== 5 * (k / 4) + (k % 4))
                $display("FAIL all4_cycle[%0d]: got %0d want %0d", k, pop_cyc[k] - pop_cyc[0], 5 * (k / 4) + (k % 4));
            else passes++;
        end
        for (int k = 0; k < 16 && k < dlog.size(); k++) begin
            checks++;
            if (dlog[k] !== word(k / 4, k % 4))
                $display("FAIL all4_data[%0d]: got %h want %h", k, dlog[k], word(k / 4, k % 4));
            else passes++;
        end
        $display("test_all_four done: pops=%0d delivered=%0d", pop_id.size(), dlog.size());
    endtask

    task automatic test_backpressure();
        do_reset();
        fill[1] = 8;
        reset   = 1'b1;
        wait_pops(2, 20, "bp_start");
        checks++; if (xfer_count !== 32'd1) $display("FAIL bp_xfer_before: got %0d want 1", xfer_count); else passes++;
        out_full_n = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (out_write !== 1'b1) $display("FAIL bp_hold_valid[%0d]: got %b want 1", c, out_write); else passes++;
            checks++; if (out_din !== word(1, 1)) $display("FAIL bp_hold_data[%0d]: got %h want %h", c, out_din, word(1, 1)); else passes++;
            checks++; if (req_read !== 4'b0000) $display("FAIL bp_hold_read[%0d]: got %b want 0000", c, req_read); else passes++;
        end
        checks++; if (pop_id.size() !== 2) $display("FAIL bp_hold_pops: got %0d want 2", pop_id.size()); else passes++;
        checks++; if (xfer_count !== 32'd1) $display("FAIL bp_hold_xfer: got %0d want 1", xfer_count); else passes++;
        out_full_n = 1'b1;
        wait_pops(8, 40, "bp_resume");
        repeat (4) @(negedge clk);
        if (pop_cyc.size() >= 5) begin
            checks++; if (pop_cyc[2] - pop_cyc[1] !== 6) $display("FAIL bp_gap12: got %0d want 6", pop_cyc[2] - pop_cyc[1]); else passes++;
            checks++; if (pop_cyc[3] - pop_cyc[2] !== 1) $display("FAIL bp_gap23: got %0d want 1", pop_cyc[3] - pop_cyc[2]); else passes++;
            checks++; if (pop_cyc[4] - pop_cyc[3] !== 2) $display("FAIL bp_gap34: got %0d want 2", pop_cyc[4] - pop_cyc[3]); else passes++;
        end
        checks++; if (dlog.size() !== 8) $display("FAIL bp_deliver_count: got %0d want 8", dlog.size()); else passes++;
        for (int k = 0; k < 8 && k < dlog.size(); k++) begin
            checks++;
            if (dlog[k] !== word(1, k))
                $display("FAIL bp_data[%0d]: got %h want %h", k, dlog[k], word(1, k));
            else passes++;
        end
        checks++; if (xfer_count !== 32'd8) $display("FAIL bp_xfer_end: got %0d want 8", xfer_count); else passes++;
        $display("test_backpressure done: delivered=%0d xfer=%0d", dlog.size(), xfer_count);
    endtask

    task automatic test_mask();
        do_reset();
        fill[1] = INF;
        fill[2] = 3;
        reset   = 1'b1;
        wait_pops(1, 20, "mask_start");
        cfg_enable[1] = 1'b0;
        #1;
        checks++; if (req_read !== 4'b0000) $display("FAIL mask_no_pop: got %b want 0000", req_read); else passes++;
        repeat (20) @(negedge clk);
        checks++; if (pop_id.size() !== 4) $display("FAIL mask_pop_count: got %0d want 4", pop_id.size()); else passes++;
        if (pop_id.size() >= 4) begin
            checks++; if (pop_id[0] !== 1) $display("FAIL mask_first_id: got %0d want 1", pop_id[0]); else passes++;
            for (int k = 1; k < 4; k++) begin
                checks++;
                if (pop_id[k] !== 2) $display("FAIL mask_id[%0d]: got %0d want 2", k, pop_id[k]); else passes++;
            end
        end
        checks++; if (grant_id !== 2'd2) $display("FAIL mask_grant_held: got %0d want 2", grant_id); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL mask_busy: got %b want 0", busy); else passes++;
        cfg_enable[1] = 1'b1;
        wait_pops(5, 20, "mask_reenable");
        if (pop_id.size() >= 5) begin
            checks++; if (pop_id[4] !== 1) $display("FAIL mask_reenable_id: got %0d want 1", pop_id[4]); else passes++;
        end
        checks++; if (grant_id !== 2'd1) $display("FAIL mask_reenable_grant: got %0d want 1", grant_id); else passes++;
        $display("test_mask done: pops=%0d grant_id=%0d", pop_id.size(), grant_id);
    endtask

    task automatic test_async_reset();
        do_reset();
        fill[0] = 5;
        reset   = 1'b1;
        wait_pops(2, 20, "arst_start");
        checks++; if (out_write !== 1'b1) $display("FAIL arst_pre_valid: got %b want 1", out_write); else passes++;
        checks++; if (xfer_count !== 32'd1) $display("FAIL arst_pre_xfer: got %0d want 1", xfer_count); else passes++;
        #2;
        reset = 1'b0;
        #1;
        checks++; if (out_write !== 1'b0) $display("FAIL arst_out_write: got %b want 0", out_write); else passes++;
        checks++; if (out_din !== 32'd0) $display("FAIL arst_out_din: got %h want 0", out_din); else passes++;
        checks++; if (req_read !== 4'b0000) $display("FAIL arst_req_read: got %b want 0000", req_read); else passes++;
        checks++; if (grant_id !== 2'd3) $display("FAIL arst_grant: got %0d want 3", grant_id); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL arst_busy: got %b want 0", busy); else passes++;
        checks++; if (xfer_count !== 32'd0) $display("FAIL arst_xfer: got %0d want 0", xfer_count); else passes++;
        repeat (3) @(negedge clk);
        checks++; if (pop_id.size() !== 2) $display("FAIL arst_no_pop_in_reset: got %0d want 2", pop_id.size()); else passes++;
        checks++; if (dlog.size() !== 1) $display("FAIL arst_delivered: got %0d want 1", dlog.size()); else passes++;
        reset = 1'b1;
        wait_pops(5, 20, "arst_resume");
        repeat (4) @(negedge clk);
        checks++; if (dlog.size() !== 4) $display("FAIL arst_total_delivered: got %0d want 4", dlog.size()); else passes++;
        if (dlog.size() >= 2) begin
            checks++; if (dlog[1] !== word(0, 2)) $display("FAIL arst_next_word: got %h want %h", dlog[1], word(0, 2)); else passes++;
        end
        checks++; if (xfer_count !== 32'd3) $display("FAIL arst_xfer_after: got %0d want 3", xfer_count); else passes++;
        $display("test_async_reset done: delivered=%0d xfer=%0d", dlog.size(), xfer_count);
    endtask

    initial begin
        cfg_enable = '1;
        out_full_n = 1'b1;
        for (int i = 0; i < NR; i++) fill[i] = 0;
        test_reset();
        test_single();
        test_all_four();
        test_backpressure();
        test_mask();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
